// File: rtl/llr_pkg.sv
// rtl/llr_pkg.sv - shared op encodings and symmetric saturation bounds for metric/LLR blocks
package llr_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_MIN = 2'd3;

  // Largest magnitude kept after clamping: 2^(width-1)-1.
  function automatic longint sym_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  // Negative bound mirrors the positive one, so -2^(width-1) is never emitted.
  function automatic longint sym_min(input int width);
    return -sym_max(width);
  endfunction

endpackage

// File: rtl/llr_sat_lane.sv
// rtl/llr_sat_lane.sv - one lane: clamp a WIDTH+1 raw result to the symmetric WIDTH range
module llr_sat_lane
  import llr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH:0]   raw,
  output logic        [WIDTH-1:0] res,
  output logic                    sat
);

  localparam logic signed [WIDTH:0] MAXV = (WIDTH + 1)'(sym_max(WIDTH));
  localparam logic signed [WIDTH:0] MINV = (WIDTH + 1)'(sym_min(WIDTH));

  // Clamp out-of-range values (including the most-negative code) and flag them.
  always_comb begin
    res = raw[WIDTH-1:0];
    sat = 1'b0;
    if (raw > MAXV) begin
      res = MAXV[WIDTH-1:0];
      sat = 1'b1;
    end else if (raw < MINV) begin
      res = MINV[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/llr_addsub_pipe.sv
// rtl/llr_addsub_pipe.sv - two-stage multi-lane saturating add/sub/max/min with flow control
module llr_addsub_pipe
  import llr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_res,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  localparam int RW = WIDTH + 1;

  logic                   en;
  logic                   s1_valid;
  logic [1:0]             s1_op;
  logic [LANES*RW-1:0]    s1_raw;
  logic [LANES*RW-1:0]    raw_c;
  logic [LANES*WIDTH-1:0] sat_res;
  logic [LANES-1:0]       sat_flag;
  logic signed [RW-1:0]   a_e;
  logic signed [RW-1:0]   b_e;
  logic signed [RW-1:0]   r_e;

  // Whole pipeline moves together; a stalled output freezes both stages.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Per-lane raw result at one extra bit so ADD/SUB can never wrap.
  always_comb begin
    raw_c = '0;
    a_e   = '0;
    b_e   = '0;
    r_e   = '0;
    for (int i = 0; i < LANES; i++) begin
      a_e = {in_a[i*WIDTH+WIDTH-1], in_a[i*WIDTH +: WIDTH]};
      b_e = {in_b[i*WIDTH+WIDTH-1], in_b[i*WIDTH +: WIDTH]};
      case (in_op)
        OP_ADD:  r_e = a_e + b_e;
        OP_SUB:  r_e = a_e - b_e;
        OP_MAX:  r_e = (a_e >= b_e) ? a_e : b_e;
        default: r_e = (a_e <= b_e) ? a_e : b_e;
      endcase
      raw_c[i*RW +: RW] = r_e;
    end
  end

  // Saturation sits between the two register stages, one instance per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    llr_sat_lane #(.WIDTH(WIDTH)) u_sat (
      .raw (s1_raw[g*RW +: RW]),
      .res (sat_res[g*WIDTH +: WIDTH]),
      .sat (sat_flag[g])
    );
  end

  // Stage registers: S1 holds op and raw results, S2 holds clamped results.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_raw    <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_sat   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_raw <= raw_c;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res <= sat_res;
        out_sat <= (s1_op == OP_ADD || s1_op == OP_SUB || s1_op == OP_MAX || s1_op == OP_MIN)
                   ? sat_flag : '0;
      end
    end
  end

  // Count delivered beats with any clamped lane; clear has priority and the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|out_sat) && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_llr_addsub_pipe.sv
// tb/tb_llr_addsub_pipe.sv - scoreboard bench for llr_addsub_pipe (WIDTH=16, LANES=2, CNT_W=4)
module tb_llr_addsub_pipe;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [1:0]  out_sat;
  logic        sat_clr;
  logic [3:0]  sat_count;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   m_s1 = 1'b0;
  bit   m_s2 = 1'b0;
  bit   stalled = 1'b0;
  bit   last_in_fire = 1'b0;
  logic [31:0] held_res;
  logic [1:0]  held_sat;

  llr_addsub_pipe #(.WIDTH(16), .LANES(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lane_model(input int op, input int a, input int b, output int r, output bit s);
    int raw;
    case (op)
      0:       raw = a + b;
      1:       raw = a - b;
      2:       raw = (a >= b) ? a : b;
      default: raw = (a <= b) ? a : b;
    endcase
    s = 1'b1;
    if (raw > 32767)       r = 32767;
    else if (raw < -32767) r = -32767;
    else begin
      r = raw;
      s = 1'b0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   r0, r1;
    bit   s0, s1;
    logic [15:0] t0, t1;
    lane_model(int'(in_op), int'($signed(in_a[15:0])), int'($signed(in_b[15:0])), r0, s0);
    lane_model(int'(in_op), int'($signed(in_a[31:16])), int'($signed(in_b[31:16])), r1, s1);
    t0 = r0[15:0];
    t1 = r1[15:0];
    e.res = {t1, t0};
    e.sat = {s1, s0};
    sb.push_back(e);
  endtask

  task automatic set_in(input int op, input int a0, input int a1, input int b0, input int b1);
    in_op = op[1:0];
    in_a  = {a1[15:0], a0[15:0]};
    in_b  = {b1[15:0], b0[15:0]};
  endtask

  // One clock: sample and score at negedge, update the valid-pipeline model at posedge.
  task automatic tick();
    bit   en_m;
    bit   out_fire;
    exp_t e;
    @(negedge clk);
    en_m = !m_s2 || out_ready;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_s2});
    check("in_ready", {63'd0, in_ready}, {63'd0, en_m});
    if (stalled) begin
      check("stall_res", {32'd0, out_res}, {32'd0, held_res});
      check("stall_sat", {62'd0, out_sat}, {62'd0, held_sat});
    end
    stalled = 1'b0;
    out_fire = m_s2 && out_ready && !rst;
    last_in_fire = in_valid && en_m && !rst;
    if (out_fire) begin
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_res", {32'd0, out_res}, {32'd0, e.res});
        check("out_sat", {62'd0, out_sat}, {62'd0, e.sat});
      end
    end
    if (m_s2 && !out_ready && !rst) begin
      stalled  = 1'b1;
      held_res = out_res;
      held_sat = out_sat;
    end
    if (last_in_fire) push_expected();
    @(posedge clk);
    if (rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else if (en_m) begin
      m_s2 = m_s1;
      m_s1 = in_valid;
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 64'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    in_op = 2'd0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_res", {32'd0, out_res}, 64'd0);
    check("rst_out_sat", {62'd0, out_sat}, 64'd0);
    check("rst_sat_count", {60'd0, sat_count}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // SUB, no saturation
    set_in(1, 100, -5, 30, 7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("sub_res", {32'd0, out_res}, 64'h0000_0000_FFF4_0046);
    check("sub_sat", {62'd0, out_sat}, 64'd0);
    tick();
    check("sub_count", {60'd0, sat_count}, 64'd0);

    // SUB overflow on both lanes
    set_in(1, 32767, -32768, -1, 1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf_res", {32'd0, out_res}, 64'h0000_0000_8001_7FFF);
    check("ovf_sat", {62'd0, out_sat}, 64'd3);
    tick();
    check("ovf_count", {60'd0, sat_count}, 64'd1);

    // MAX / MIN including ties and the most-negative code
    in_valid = 1'b1;
    set_in(2, -3, 9, -3, 12); tick();
    set_in(3, -3, 9, -3, 12); tick();
    set_in(2, -32768, -32768, -32768, -32768); tick();
    in_valid = 1'b0;
    drain();
    check("maxmin_count", {60'd0, sat_count}, 64'd2);

    // Back-to-back with out_ready pattern 1,0,0,1
    sent = 0;
    cyc  = 0;
    in_valid = 1'b1;
    in_op = 2'($urandom_range(0, 3)); in_a = $urandom; in_b = $urandom;
    while (sent < 8 && cyc < 100) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      tick();
      cyc++;
      if (last_in_fire) begin
        sent++;
        in_op = 2'($urandom_range(0, 3)); in_a = $urandom; in_b = $urandom;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("b2b_sent", sent, 64'd8);
    drain();

    // Counter saturates at all-ones
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    check("clr_count", {60'd0, sat_count}, 64'd0);
    set_in(0, 32767, 32767, 1, 1); in_valid = 1'b1;
    repeat (19) tick();
    in_valid = 1'b0;
    drain();
    check("count_hold", {60'd0, sat_count}, 64'd15);

    // Clear wins over a simultaneous saturated handshake
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    check("clr_vs_inc", {60'd0, sat_count}, 64'd0);
    check("clr_drained", sb.size(), 64'd0);

    // Saturated beat to make the counter nonzero, then reset with two in flight
    set_in(0, 32767, 0, 1, 0); in_valid = 1'b1; tick();
    in_valid = 1'b0; drain();
    check("pre_rst_count", {60'd0, sat_count}, 64'd1);
    set_in(0, 1, 2, 3, 4); in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_res", {32'd0, out_res}, 64'd0);
    check("midrst_out_sat", {62'd0, out_sat}, 64'd0);
    check("midrst_count", {60'd0, sat_count}, 64'd0);
    sb.delete();
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
